// File: rtl/mmio_display_ctrl.sv
// Memory-mapped 4-digit seven-segment display controller (DATA/CTRL/STATUS registers).
// Define DISP_DECIMAL_EN to show DATA in decimal through a sequential double-dabble converter.
module mmio_display_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int          REFRESH_DIV = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        MmioSel,
  output logic [31:0] MmioReadData,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam logic [31:0] DATA_ADDR   = BASE_ADDR;
  localparam logic [31:0] CTRL_ADDR   = BASE_ADDR + 32'd4;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd8;

  localparam int            PW         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  // Address decode ignores the byte offset bits.
  logic hit_data;
  logic hit_ctrl;
  logic hit_status;
  logic data_we;
  logic ctrl_we;

  assign hit_data   = (ALUResult[31:2] == DATA_ADDR[31:2]);
  assign hit_ctrl   = (ALUResult[31:2] == CTRL_ADDR[31:2]);
  assign hit_status = (ALUResult[31:2] == STATUS_ADDR[31:2]);
  assign data_we    = MemWrite & hit_data;
  assign ctrl_we    = MemWrite & hit_ctrl;

  logic unused_bits;
  assign unused_bits = ^{WriteData[31:16], ALUResult[1:0]};

  logic [15:0]   data_q;
  logic          en_q;
  logic [7:0]    frames_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic [15:0]   disp_q;
  logic          busy;

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q <= 16'h0000;
      en_q   <= 1'b1;
    end else begin
      if (data_we) data_q <= WriteData[15:0];
      if (ctrl_we) en_q   <= WriteData[0];
    end
  end

  // Digit scan runs free of bus traffic and of the enable bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q  <= '0;
      idx_q    <= 2'd0;
      frames_q <= 8'h00;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
      idx_q   <= idx_q + 2'd1;
      if (idx_q == 2'd3) frames_q <= frames_q + 8'h01;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

`ifdef DISP_DECIMAL_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } conv_state_t;

  conv_state_t state;
  logic [15:0] bin_q;
  logic [15:0] bcd_q;
  logic [15:0] bcd_adj;
  logic [3:0]  cnt_q;
  logic [15:0] clamped;
  logic        busy_q;

  assign clamped = (WriteData[15:0] > 16'd9999) ? 16'd9999 : WriteData[15:0];

  // Add-3 correction applied to every BCD digit before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // A new DATA write always restarts the conversion, even mid-flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      bin_q  <= 16'h0000;
      bcd_q  <= 16'h0000;
      cnt_q  <= 4'd0;
      disp_q <= 16'h0000;
      busy_q <= 1'b0;
    end else if (data_we) begin
      state  <= ST_SHIFT;
      bin_q  <= clamped;
      bcd_q  <= 16'h0000;
      cnt_q  <= 4'd0;
      busy_q <= 1'b1;
    end else begin
      case (state)
        ST_SHIFT: begin
          bcd_q <= {bcd_adj[14:0], bin_q[15]};
          bin_q <= {bin_q[14:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state <= ST_LOAD;
        end
        ST_LOAD: begin
          disp_q <= bcd_q;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
`else
  always_ff @(posedge CLK) begin
    if (RST)          disp_q <= 16'h0000;
    else if (data_we) disp_q <= WriteData[15:0];
  end

  assign busy = 1'b0;
`endif

  always_comb begin
    MmioSel      = hit_data | hit_ctrl | hit_status;
    MmioReadData = 32'h0000_0000;
    if (hit_data)        MmioReadData = {16'h0000, data_q};
    else if (hit_ctrl)   MmioReadData = {31'h0000_0000, en_q};
    else if (hit_status) MmioReadData = {16'h0000, frames_q, 7'h00, busy};
  end

  logic [3:0] nibble;

  always_comb begin
    case (idx_q)
      2'd0:    nibble = disp_q[3:0];
      2'd1:    nibble = disp_q[7:4];
      2'd2:    nibble = disp_q[11:8];
      default: nibble = disp_q[15:12];
    endcase
  end

  assign an = en_q ? ~(4'b0001 << idx_q) : 4'b1111;

  // Segment order {g,f,e,d,c,b,a}, active low.
  always_comb begin
    case (nibble)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end

endmodule

// File: tb/tb_mmio_display_ctrl.sv
// Directed plus randomized bench for mmio_display_ctrl against a cycle-count based display model.
// Decimal-mode steps are included when DISP_DECIMAL_EN is defined.
module tb_mmio_display_ctrl;

  localparam int          DIV  = 4;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] ALUResult = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic        MmioSel;
  logic [31:0] MmioReadData;
  logic [3:0]  an;
  logic [6:0]  seg;

  mmio_display_ctrl #(.BASE_ADDR(BASE), .REFRESH_DIV(DIV)) dut (
    .CLK(CLK), .RST(RST), .MemWrite(MemWrite), .ALUResult(ALUResult),
    .WriteData(WriteData), .MmioSel(MmioSel), .MmioReadData(MmioReadData),
    .an(an), .seg(seg)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // reference model state
  int          cyc = 0;
  int          edges = 0;
  logic [15:0] m_data = 16'h0;
  logic [15:0] m_disp = 16'h0;
  logic        m_en = 1'b1;
  bit          pend = 0;
  int          pend_due = 0;
  logic [15:0] pend_val = 16'h0;
  logic [6:0]  seg_tab [16];

  function automatic logic [15:0] to_bcd(logic [15:0] v);
    int c;
    c = (v > 16'd9999) ? 9999 : int'(v);
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  function automatic int m_idx();
    return (cyc / DIV) % 4;
  endfunction

  function automatic logic [7:0] m_frames();
    return 8'((cyc / (DIV * 4)) % 256);
  endfunction

  function automatic logic [32:0] model_read(logic [31:0] a);
    logic [29:0] w;
    w = a[31:2];
    if (w == BASE[31:2])                return {1'b1, 16'h0, m_data};
    if (w == BASE[31:2] + 30'd1)        return {1'b1, 31'h0, m_en};
    if (w == BASE[31:2] + 30'd2)        return {1'b1, 16'h0, m_frames(), 7'h0, pend};
    return 33'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge; the model applies what the bench was driving at that edge.
  task automatic tick();
    logic [29:0] w;
    @(posedge CLK);
    edges++;
    w = ALUResult[31:2];
    if (RST) begin
      cyc = 0; m_data = 16'h0; m_disp = 16'h0; m_en = 1'b1; pend = 0;
    end else begin
      cyc++;
      if (MemWrite && w == BASE[31:2]) begin
        m_data = WriteData[15:0];
`ifdef DISP_DECIMAL_EN
        pend = 1; pend_val = to_bcd(WriteData[15:0]); pend_due = edges + 17;
`else
        m_disp = WriteData[15:0];
`endif
      end else if (pend && edges == pend_due) begin
        m_disp = pend_val; pend = 0;
      end
      if (MemWrite && w == BASE[31:2] + 30'd1) m_en = WriteData[0];
    end
    #1;
  endtask

  task automatic check_outputs();
    logic [3:0] exp_an;
    exp_an = m_en ? ~(4'b0001 << m_idx()) : 4'b1111;
    check("an", 32'(an), 32'(exp_an));
    check("seg", 32'(seg), 32'(seg_tab[m_disp[m_idx()*4 +: 4]]));
  endtask

  task automatic do_read(input logic [31:0] a);
    logic [32:0] r;
    MemWrite = 1'b0;
    ALUResult = a;
    #1;
    r = model_read(a);
    exp_q.push_back({31'h0, r[32]});
    exp_q.push_back(r[31:0]);
    check("sel", 32'(MmioSel), exp_q.pop_front());
    check("rdata", MmioReadData, exp_q.pop_front());
  endtask

  // driver: one bus store, then outputs checked after the edge
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; ALUResult = a; WriteData = d;
    tick();
    MemWrite = 1'b0; ALUResult = 32'h0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_outputs();
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; MemWrite = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  logic [3:0] an_seq [4];

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    an_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // reset state
    do_reset();
    do_reset();
    check("reset_an", 32'(an), 32'(4'b1110));
    check("reset_seg", 32'(seg), 32'(7'b1000000));
    do_read(BASE);
    do_read(BASE + 32'd4);
    do_read(BASE + 32'd8);

    // digit stepping and first frame
    for (int k = 0; k < 4; k++) begin
      idle(DIV);
      check("an_step", 32'(an), 32'(an_seq[k]));
    end
    ALUResult = BASE + 32'd8;
    #1;
    check("frames_1", MmioReadData, 32'h0000_0100);

    // hex write and readback
    bus_write(BASE, 32'h0000_ABCD);
    do_read(BASE);
    check("data_abcd", MmioReadData, 32'h0000_ABCD);
    idle(4 * DIV);

    // enable off then back on
    bus_write(BASE + 32'd4, 32'h0);
    check("an_off", 32'(an), 32'(4'b1111));
    idle(2 * DIV + 1);
    bus_write(BASE + 32'd4, 32'h1);
    do_read(BASE + 32'd4);
    check("ctrl_1", MmioReadData, 32'h1);

    // non-matching address, STATUS write, byte-offset aliasing, back-to-back stores
    bus_write(32'h0000_0200, 32'h0000_1111);
    do_read(32'h0000_0200);
    check("miss_sel", 32'(MmioSel), 32'h0);
    do_read(BASE);
    bus_write(BASE + 32'd8, 32'hFFFF_FFFF);
    do_read(BASE + 32'd8);
    bus_write(BASE + 32'd3, 32'h0000_5678);
    do_read(BASE + 32'd1);
    bus_write(BASE, 32'h0000_1357);
    bus_write(BASE, 32'h0000_2468);
    do_read(BASE);
    idle(4 * DIV);

`ifdef DISP_DECIMAL_EN
    // decimal conversion, clamping, restart, reset abort
    bus_write(BASE, 32'd1234);
    for (int i = 0; i < 20; i++) begin
      do_read(BASE + 32'd8);
      tick();
      check_outputs();
    end
    idle(4 * DIV);
    bus_write(BASE, 32'h0000_FFFF);
    idle(20);
    bus_write(BASE, 32'd500);
    idle(2);
    bus_write(BASE, 32'd42);
    idle(20);
    bus_write(BASE, 32'd777);
    idle(5);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    do_read(BASE + 32'd8);
    check_outputs();
    idle(20);
`endif

    // randomized bus traffic
    for (int i = 0; i < 400; i++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      case ($urandom_range(0, 4))
        0:       a = BASE + 32'($urandom_range(0, 3));
        1:       a = BASE + 32'd4 + 32'($urandom_range(0, 3));
        2:       a = BASE + 32'd8 + 32'($urandom_range(0, 3));
        3:       a = 32'h0000_0200;
        default: a = $urandom;
      endcase
      if (kind == 0) begin
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_outputs();
      end else if (kind < 5) begin
        bus_write(a, $urandom);
      end else begin
        idle(1);
      end
      do_read(a);
    end

    // FRAMES wraps 255 -> 0
    do_reset();
    for (int i = 0; i < 256 * 4 * DIV; i++) begin
      tick();
      if (i == 255 * 4 * DIV - 1) begin
        ALUResult = BASE + 32'd8;
        #1;
        check("frames_255", MmioReadData, 32'h0000_FF00);
      end
    end
    do_read(BASE + 32'd8);
    check("frames_wrap", MmioReadData, 32'h0000_0000);
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
